i2cmb_byte_engine: RTL

- Byte-level I2C master engine that sits directly downstream of the I2CMB Wishbone register/command block.
- Accepts one bus command at a time (START, STOP, WRITE byte, READ with ACK/NAK) and returns one response per command.
- Produces open-drain SCL/SDA drive enables and samples the pad inputs.
- Handles clock stretching and arbitration loss.

---
 rtl/i2cmb_byte_pkg.sv | 44 ++++
 rtl/i2cmb_quarter_timer.sv | 46 ++++
 rtl/i2cmb_byte_engine.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/i2cmb_byte_pkg.sv
// rtl/i2cmb_byte_pkg.sv - shared types and constants for the I2CMB byte engine
//
// Contents:
//   i2cmb_cmd_t   command codes offered by the register block
//   i2cmb_rsp_t   response status codes returned per command
//   phase_t       SCL quarter-period index q0..q3
//   state_t       byte engine FSM states
//   BITS_PER_BYTE data bits plus the acknowledge slot
package i2cmb_byte_pkg;

  typedef enum logic [2:0] {
    CMD_START    = 3'd0,
    CMD_STOP     = 3'd1,
    CMD_WRITE    = 3'd2,
    CMD_READ_ACK = 3'd3,
    CMD_READ_NAK = 3'd4
  } i2cmb_cmd_t;

  typedef enum logic [1:0] {
    RSP_DONE     = 2'd0,
    RSP_NAK      = 2'd1,
    RSP_ARB_LOST = 2'd2,
    RSP_ERROR    = 2'd3
  } i2cmb_rsp_t;

  typedef enum logic [1:0] {
    PH_Q0 = 2'd0,
    PH_Q1 = 2'd1,
    PH_Q2 = 2'd2,
    PH_Q3 = 2'd3
  } phase_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_STOP  = 3'd2,
    ST_BIT   = 3'd3,
    ST_ACK   = 3'd4,
    ST_RESP  = 3'd5
  } state_t;

  localparam int BITS_PER_BYTE = 9;

endpackage

// File: rtl/i2cmb_quarter_timer.sv
// rtl/i2cmb_quarter_timer.sv - SCL quarter-period prescaler and phase counter
//
// Ports:
//   clk_i, rst_i   clock, asynchronous active-high reset
//   enable         run the timer; when low the timer parks at q0, count 0
//   stretch_hold   freeze the prescaler (slave is stretching SCL)
//   q_end          last cycle of the current quarter
//   phase          current quarter q0..q3
module i2cmb_quarter_timer
  import i2cmb_byte_pkg::*;
#(
  parameter int CLK_DIV = 25,
  parameter int CNT_W   = $clog2(CLK_DIV)
) (
  input  logic   clk_i,
  input  logic   rst_i,
  input  logic   enable,
  input  logic   stretch_hold,
  output logic   q_end,
  output phase_t phase
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] cnt;
  logic [1:0]       ph_q;

  assign q_end = enable && !stretch_hold && (cnt == CNT_LAST);
  assign phase = phase_t'(ph_q);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt  <= '0;
      ph_q <= 2'd0;
    end else if (!enable) begin
      cnt  <= '0;
      ph_q <= 2'd0;
    end else if (q_end) begin
      cnt  <= '0;
      ph_q <= ph_q + 2'd1;
    end else if (!stretch_hold) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/i2cmb_byte_engine.sv
// rtl/i2cmb_byte_engine.sv - byte-level I2C master engine (START/STOP/WRITE/READ)
//
// Ports:
//   clk_i, rst_i                 clock, asynchronous active-high reset
//   cmd_valid_i/cmd_ready_o      command handshake, one command in flight
//   cmd_code_i, cmd_data_i       command code and WRITE byte
//   rsp_valid_o                  single-cycle response pulse
//   rsp_status_o, rsp_data_o     response status and last received byte
//   bus_busy_o                   engine owns the bus
//   scl_i, sda_i                 synchronised pad inputs
//   scl_oe_o, sda_oe_o           open-drain pull-low enables
module i2cmb_byte_engine
  import i2cmb_byte_pkg::*;
#(
  parameter int CLK_DIV = 25,
  parameter int CNT_W   = $clog2(CLK_DIV)
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       cmd_valid_i,
  output logic       cmd_ready_o,
  input  logic [2:0] cmd_code_i,
  input  logic [7:0] cmd_data_i,
  output logic       rsp_valid_o,
  output logic [1:0] rsp_status_o,
  output logic [7:0] rsp_data_o,
  output logic       bus_busy_o,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       scl_oe_o,
  output logic       sda_oe_o
);

  localparam logic [3:0] LAST_DATA_BIT = 4'(BITS_PER_BYTE - 2);

  state_t     state;
  i2cmb_cmd_t cmd;
  i2cmb_cmd_t code_in;
  logic [7:0] sreg;
  logic [3:0] bit_idx;
  logic       ack_nak;
  logic       cmd_legal;
  logic       late_half;
  logic       stretch_hold;
  logic       timer_en;
  logic       q_end;
  phase_t     phase;

  assign code_in   = i2cmb_cmd_t'(cmd_code_i);
  assign late_half = (phase == PH_Q2) || (phase == PH_Q3);
  assign timer_en  = (state == ST_START) || (state == ST_STOP) ||
                     (state == ST_BIT)   || (state == ST_ACK);

  // The timer waits for SCL to actually rise in the quarter where the engine
  // first releases it; a slave holding SCL low stretches that quarter.
  always_comb begin
    stretch_hold = 1'b0;
    if (!scl_i) begin
      if ((state == ST_START || state == ST_STOP) && phase == PH_Q1)
        stretch_hold = 1'b1;
      if ((state == ST_BIT || state == ST_ACK) && phase == PH_Q2)
        stretch_hold = 1'b1;
    end
  end

  // Data commands and STOP need the bus; START is always allowed.
  always_comb begin
    cmd_legal = 1'b0;
    case (code_in)
      CMD_START:    cmd_legal = 1'b1;
      CMD_STOP,
      CMD_WRITE,
      CMD_READ_ACK,
      CMD_READ_NAK: cmd_legal = bus_busy_o;
      default:      cmd_legal = 1'b0;
    endcase
  end

  i2cmb_quarter_timer #(
    .CLK_DIV (CLK_DIV),
    .CNT_W   (CNT_W)
  ) u_timer (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .enable       (timer_en),
    .stretch_hold (stretch_hold),
    .q_end        (q_end),
    .phase        (phase)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state        <= ST_IDLE;
      cmd          <= CMD_START;
      sreg         <= 8'h00;
      bit_idx      <= 4'd0;
      ack_nak      <= 1'b0;
      cmd_ready_o  <= 1'b1;
      rsp_valid_o  <= 1'b0;
      rsp_status_o <= RSP_DONE;
      rsp_data_o   <= 8'h00;
      bus_busy_o   <= 1'b0;
      scl_oe_o     <= 1'b0;
      sda_oe_o     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cmd_valid_i) begin
            cmd_ready_o <= 1'b0;
            cmd         <= code_in;
            bit_idx     <= 4'd0;
            if (!cmd_legal) begin
              state        <= ST_RESP;
              rsp_valid_o  <= 1'b1;
              rsp_status_o <= RSP_ERROR;
            end else begin
              case (code_in)
                CMD_START: begin
                  // From idle the bus is already high, so q0 leaves SCL alone.
                  state    <= ST_START;
                  scl_oe_o <= bus_busy_o;
                  sda_oe_o <= 1'b0;
                end
                CMD_STOP: begin
                  state    <= ST_STOP;
                  scl_oe_o <= 1'b1;
                  sda_oe_o <= 1'b1;
                end
                CMD_WRITE: begin
                  state    <= ST_BIT;
                  sreg     <= cmd_data_i;
                  scl_oe_o <= 1'b1;
                  sda_oe_o <= ~cmd_data_i[7];
                end
                default: begin
                  state    <= ST_BIT;
                  scl_oe_o <= 1'b1;
                  sda_oe_o <= 1'b0;
                end
              endcase
            end
          end
        end

        ST_START: begin
          if (q_end) begin
            case (phase)
              PH_Q0: scl_oe_o <= 1'b0;
              PH_Q1: sda_oe_o <= 1'b1;
              PH_Q2: scl_oe_o <= 1'b1;
              PH_Q3: begin
                bus_busy_o   <= 1'b1;
                state        <= ST_RESP;
                rsp_valid_o  <= 1'b1;
                rsp_status_o <= RSP_DONE;
              end
            endcase
          end
        end

        ST_STOP: begin
          if (late_half && !sda_i) begin
            state        <= ST_RESP;
            rsp_valid_o  <= 1'b1;
            rsp_status_o <= RSP_ARB_LOST;
            scl_oe_o     <= 1'b0;
            sda_oe_o     <= 1'b0;
            bus_busy_o   <= 1'b0;
          end else if (q_end) begin
            case (phase)
              PH_Q0: scl_oe_o <= 1'b0;
              PH_Q1: sda_oe_o <= 1'b0;
              PH_Q2: ;
              PH_Q3: begin
                bus_busy_o   <= 1'b0;
                state        <= ST_RESP;
                rsp_valid_o  <= 1'b1;
                rsp_status_o <= RSP_DONE;
              end
            endcase
          end
        end

        ST_BIT: begin
          // Another master driving 0 while we send a released 1 wins the bus.
          if (cmd == CMD_WRITE && !sda_oe_o && late_half && !sda_i) begin
            state        <= ST_RESP;
            rsp_valid_o  <= 1'b1;
            rsp_status_o <= RSP_ARB_LOST;
            scl_oe_o     <= 1'b0;
            sda_oe_o     <= 1'b0;
            bus_busy_o   <= 1'b0;
          end else if (q_end) begin
            case (phase)
              PH_Q0: ;
              PH_Q1: scl_oe_o <= 1'b0;
              // One register serves both directions: shifting out the sent
              // bit exposes the next one in sreg[7] while shifting in sda_i.
              PH_Q2: sreg <= {sreg[6:0], sda_i};
              PH_Q3: begin
                scl_oe_o <= 1'b1;
                if (bit_idx == LAST_DATA_BIT) begin
                  state    <= ST_ACK;
                  sda_oe_o <= (cmd == CMD_READ_ACK);
                end else begin
                  bit_idx  <= bit_idx + 4'd1;
                  sda_oe_o <= (cmd == CMD_WRITE) && !sreg[7];
                end
              end
            endcase
          end
        end

        ST_ACK: begin
          if (q_end) begin
            case (phase)
              PH_Q0: ;
              PH_Q1: scl_oe_o <= 1'b0;
              PH_Q2: ack_nak <= sda_i;
              PH_Q3: begin
                scl_oe_o    <= 1'b1;
                state       <= ST_RESP;
                rsp_valid_o <= 1'b1;
                if (cmd == CMD_WRITE) begin
                  rsp_status_o <= ack_nak ? RSP_NAK : RSP_DONE;
                end else begin
                  rsp_status_o <= RSP_DONE;
                  rsp_data_o   <= sreg;
                end
              end
            endcase
          end
        end

        ST_RESP: begin
          rsp_valid_o <= 1'b0;
          cmd_ready_o <= 1'b1;
          state       <= ST_IDLE;
        end

        default: begin
          state       <= ST_IDLE;
          rsp_valid_o <= 1'b0;
          cmd_ready_o <= 1'b1;
        end
      endcase
    end
  end

endmodule
